load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_BITS, default 8, sets the width of memory data and of lsu_out.
REQ-002 Parameter ADDR_BITS, default 8, sets the memory address width; the address is taken from rs[ADDR_BITS-1:0].
REQ-003 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of WAITING cycles before abort; legal range 1..255.
REQ-004 Port clk, input, 1, is the clock; reset, input, 1, is the synchronous active-high reset.
REQ-005 Port enable, input, 1, is the thread-active flag; when low the unit SHALL ignore all requests.
REQ-006 Port core_state, input, 3, is the core phase: REQUEST=3'b011, UPDATE=3'b110.
REQ-007 Ports decoded_mem_read_enable and decoded_mem_write_enable, input, 1 each, are the LDR and STR decode flags.
REQ-008 Ports rs and rt, input, 8 each, carry the register-file operands: rs is the address and rt is the store data.
REQ-009 Read channel ports:
- mem_read_valid, output, 1;
- mem_read_address, output, ADDR_BITS;
- mem_read_ready, input, 1;
- mem_read_data, input, DATA_BITS.
REQ-010 Write channel ports:
- mem_write_valid, output, 1;
- mem_write_address, output, ADDR_BITS;
- mem_write_data, output, DATA_BITS;
- mem_write_ready, input, 1.
REQ-011 Port lsu_state, output, 2, encodes the FSM state: IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
REQ-012 Port lsu_out, output, DATA_BITS, is the loaded data consumed by the register file in its MEMORY input selection.
REQ-013 Port lsu_error, output, 1, flags that the last access timed out.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 IDLE -> REQUESTING: taken at an edge where enable=1, core_state=REQUEST and either decode flag is 1; the operation type is latched at this edge.
REQ-016 If both decode flags are 1, the unit SHALL perform a read only.
REQ-017 REQUESTING -> WAITING: taken unconditionally on the next edge.
- That edge SHALL set the matching valid output to 1.
- It SHALL latch the address from rs[ADDR_BITS-1:0] and, for a write, the data from rt[DATA_BITS-1:0].
- It SHALL clear lsu_error and the timeout counter.
REQ-018 In WAITING, the valid, address and data outputs SHALL be held stable until the matching ready is sampled high.
REQ-019 WAITING -> DONE (normal completion) at the edge where the matching ready is sampled 1:
- valid SHALL drop to 0;
- for a read, lsu_out SHALL capture mem_read_data.
REQ-020 Ready is ignored in every state except WAITING; a ready on the channel not in use is always ignored.
REQ-021 The timeout counter (8 bits, saturating) SHALL increment on each WAITING cycle without ready.
REQ-022 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with valid=0 and lsu_error=1, and lsu_out SHALL hold its previous value.
REQ-023 If ready arrives in the same cycle the counter hits the limit, normal completion SHALL win.
REQ-024 DONE -> IDLE at the edge where core_state=UPDATE; the FSM SHALL stay in DONE otherwise.
REQ-025 lsu_out SHALL hold its value across IDLE so the register file can sample it during UPDATE.
REQ-026 When enable=0, the FSM SHALL not leave IDLE; if enable falls mid-transaction, the transaction SHALL still complete.
REQ-027 Minimum latency is 3 edges from the REQUEST edge to DONE, with ready high on the first WAITING cycle.

Reset
REQ-028 On reset the unit SHALL set lsu_state=IDLE, zero all valid, address and data outputs, set lsu_out=0 and lsu_error=0, and zero the counter.
REQ-029 Reset SHALL take priority over enable.
REQ-030 Reset during WAITING SHALL drop valid on that same edge, with no completion recorded.

Structure
REQ-031 The LSU state encodings, the core_state constants REQUEST and UPDATE, and the default TIMEOUT_CYCLES SHALL live in the shared GPU package.
REQ-032 The timeout counter SHALL be a sub-module named lsu_timeout_counter, with ports clear, count_en and expired.
REQ-033 The remainder of the unit SHALL be a single FSM with no further sub-modules.

Verification
REQ-034 Read: rs=0x12, LDR, REQUEST, then ready=1 with data=0xA5 on the first WAITING cycle -> mem_read_valid high for 1 cycle, address 0x12, lsu_out=0xA5, DONE after 3 edges.
REQ-035 Write: rs=0x40, rt=0x7E, STR, ready delayed 5 cycles -> valid, address 0x40 and data 0x7E all stable for 6 cycles; lsu_out unchanged.
REQ-036 Timeout: TIMEOUT_CYCLES=4, no ready -> DONE with lsu_error=1 after 4 WAITING cycles; lsu_error clears on the next request.
REQ-037 Both LDR and STR set -> only mem_read_valid rises; mem_write_valid stays 0.
REQ-038 Reset asserted in the second WAITING cycle -> next edge shows IDLE, valid=0, lsu_out=0; a later request proceeds normally.
REQ-039 enable=0 with LDR and REQUEST -> lsu_state stays IDLE and no valid is raised.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared GPU definitions: LSU state encoding, core phase codes,
// and the default memory timeout.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_timeout_counter.sv
// Saturating 8-bit wait counter; expired flags the wait cycle
// whose increment would reach LIMIT.
module lsu_timeout_counter
  import load_store_unit_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (count_en && count != 8'hff)
      count <= count + 8'd1;
  end

  // Qualified by count_en so a same-cycle ready always wins.
  assign expired = count_en && (count >= LAST);

endmodule

// File: rtl/load_store_unit.sv
// Per-thread load/store unit: one memory access per core
// REQUEST phase, result held for the UPDATE phase.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [7:0]           rs,
  input  logic [7:0]           rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  lsu_state_t state;
  lsu_state_t state_nx;

  logic op_read;
  logic start;
  logic ready_hit;
  logic count_en;
  logic timer_clear;
  logic expired;

  lsu_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .count_en(count_en),
    .expired (expired)
  );

  always_comb begin
    start = enable
      && core_state == CORE_REQUEST
      && (decoded_mem_read_enable
          || decoded_mem_write_enable);
    ready_hit = op_read ? mem_read_ready
                        : mem_write_ready;
    count_en    = (state == LSU_WAITING) && !ready_hit;
    timer_clear = (state == LSU_REQUESTING);
    state_nx    = state;
    unique case (state)
      LSU_IDLE:
        if (start) state_nx = LSU_REQUESTING;
      LSU_REQUESTING:
        state_nx = LSU_WAITING;
      LSU_WAITING:
        if (ready_hit || expired) state_nx = LSU_DONE;
      LSU_DONE:
        if (core_state == CORE_UPDATE) state_nx = LSU_IDLE;
      default:
        state_nx = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= LSU_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_read           <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
      lsu_error         <= 1'b0;
    end else begin
      unique case (state)
        LSU_IDLE: begin
          // Read wins when both decode flags are set.
          if (start) op_read <= decoded_mem_read_enable;
        end
        LSU_REQUESTING: begin
          lsu_error <= 1'b0;
          if (op_read) begin
            mem_read_valid   <= 1'b1;
            mem_read_address <= rs[ADDR_BITS-1:0];
          end else begin
            mem_write_valid   <= 1'b1;
            mem_write_address <= rs[ADDR_BITS-1:0];
            mem_write_data    <= rt[DATA_BITS-1:0];
          end
        end
        LSU_WAITING: begin
          if (ready_hit) begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            if (op_read) lsu_out <= mem_read_data;
          end else if (expired) begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            lsu_error       <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign lsu_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: main instance at the default
// timeout plus a second instance with TIMEOUT_CYCLES=4.
module tb_load_store_unit;

  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;
  localparam logic [2:0] NOP = 3'b000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       en_to = 1'b0;
  logic [2:0] core_state = NOP;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] rs = 8'h00;
  logic [7:0] rt = 8'h00;
  logic       rrdy = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       wrdy = 1'b0;

  logic       rv, wv, rv_to, wv_to;
  logic [7:0] ra, wa, wd, ra_to, wa_to, wd_to;
  logic [1:0] st, st_to;
  logic [7:0] out, out_to;
  logic       err, err_to;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .enable(en),
    .core_state(core_state),
    .decoded_mem_read_enable(rd_en),
    .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(rv), .mem_read_address(ra),
    .mem_read_ready(rrdy), .mem_read_data(rdata),
    .mem_write_valid(wv), .mem_write_address(wa),
    .mem_write_data(wd), .mem_write_ready(wrdy),
    .lsu_state(st), .lsu_out(out), .lsu_error(err)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .enable(en_to),
    .core_state(core_state),
    .decoded_mem_read_enable(rd_en),
    .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(rv_to), .mem_read_address(ra_to),
    .mem_read_ready(rrdy), .mem_read_data(rdata),
    .mem_write_valid(wv_to), .mem_write_address(wa_to),
    .mem_write_data(wd_to), .mem_write_ready(wrdy),
    .lsu_state(st_to), .lsu_out(out_to), .lsu_error(err_to)
  );

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] out;
    bit         err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the unit in its first WAITING cycle.
  task automatic issue(input bit rd, input bit wr,
                       input logic [7:0] a,
                       input logic [7:0] d);
    rd_en = rd;
    wr_en = wr;
    rs = a;
    rt = d;
    core_state = REQ;
    step();
    rd_en = 1'b0;
    wr_en = 1'b0;
    core_state = NOP;
    step();
    rs = 8'hee;
    rt = 8'hee;
  endtask

  task automatic finish_txn(input logic [7:0] exp_out);
    step();
    chk("done_hold", st, 2'b11);
    core_state = UPD;
    step();
    core_state = NOP;
    chk("back_idle", st, 2'b00);
    chk("out_hold_idle", out, exp_out);
  endtask

  // Monitor: checks channel outputs while valid, retires on DONE.
  exp_t e;
  int   cyc = 0;
  bit   saw_r = 1'b0;
  bit   saw_w = 1'b0;
  logic [1:0] prev_st = 2'b00;

  always @(negedge clk) begin
    if (reset) begin
      cyc = 0;
      saw_r = 1'b0;
      saw_w = 1'b0;
      prev_st = 2'b00;
    end else begin
      if (rv || wv) begin
        cyc++;
        saw_r |= rv;
        saw_w |= wv;
        if (q.size() > 0) begin
          if (rv) chk("rd_addr", ra, q[0].addr);
          if (wv) begin
            chk("wr_addr", wa, q[0].addr);
            chk("wr_data", wd, q[0].wdata);
          end
        end
      end
      if (st == 2'b11 && prev_st != 2'b11) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_pending: DONE with no expected entry");
        end else begin
          e = q.pop_front();
          chk("lsu_out", out, e.out);
          chk("lsu_error", err, e.err);
          chk("valid_cycles", cyc, e.cyc);
          chk("saw_read", saw_r, e.rd);
          chk("saw_write", saw_w, !e.rd);
        end
        cyc = 0;
        saw_r = 1'b0;
        saw_w = 1'b0;
      end
      prev_st = st;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    chk("rst_state", st, 2'b00);
    chk("rst_rvalid", rv, 1'b0);
    chk("rst_wvalid", wv, 1'b0);
    chk("rst_raddr", ra, 8'h00);
    chk("rst_waddr", wa, 8'h00);
    chk("rst_wdata", wd, 8'h00);
    chk("rst_out", out, 8'h00);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    en = 1'b1;
    step();

    // Read, ready on first WAITING cycle
    q.push_back('{1'b1, 8'h12, 8'h00, 8'ha5, 1'b0, 1});
    issue(1'b1, 1'b0, 8'h12, 8'h00);
    rrdy = 1'b1;
    rdata = 8'ha5;
    step();
    rrdy = 1'b0;
    chk("read_3edges", st, 2'b11);
    finish_txn(8'ha5);

    // Write, ready delayed 5 cycles; read ready must be ignored
    q.push_back('{1'b0, 8'h40, 8'h7e, 8'ha5, 1'b0, 6});
    issue(1'b0, 1'b1, 8'h40, 8'h7e);
    rrdy = 1'b1;
    repeat (5) step();
    rrdy = 1'b0;
    chk("write_wait", st, 2'b10);
    wrdy = 1'b1;
    step();
    wrdy = 1'b0;
    finish_txn(8'ha5);

    // Both flags: read only
    q.push_back('{1'b1, 8'h30, 8'h00, 8'h3c, 1'b0, 1});
    issue(1'b1, 1'b1, 8'h30, 8'h11);
    rrdy = 1'b1;
    rdata = 8'h3c;
    step();
    rrdy = 1'b0;
    finish_txn(8'h3c);

    // Disabled thread ignores request
    en = 1'b0;
    rd_en = 1'b1;
    core_state = REQ;
    rs = 8'h66;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_state", st, 2'b00);
      chk("dis_rvalid", rv, 1'b0);
    end
    rd_en = 1'b0;
    core_state = NOP;
    en = 1'b1;
    step();

    // Reset in second WAITING cycle
    q.push_back('{1'b1, 8'h55, 8'h00, 8'h00, 1'b0, 2});
    issue(1'b1, 1'b0, 8'h55, 8'h00);
    step();
    reset = 1'b1;
    step();
    chk("wrst_state", st, 2'b00);
    chk("wrst_rvalid", rv, 1'b0);
    chk("wrst_out", out, 8'h00);
    q.delete();
    reset = 1'b0;
    step();

    // Request after reset; enable drops mid-transaction
    q.push_back('{1'b1, 8'h21, 8'h00, 8'h99, 1'b0, 3});
    issue(1'b1, 1'b0, 8'h21, 8'h00);
    en = 1'b0;
    repeat (2) step();
    rrdy = 1'b1;
    rdata = 8'h99;
    step();
    rrdy = 1'b0;
    finish_txn(8'h99);

    // Timeout instance (limit 4)
    en_to = 1'b1;
    issue(1'b1, 1'b0, 8'h44, 8'h00);
    rrdy = 1'b1;
    rdata = 8'h5a;
    step();
    rrdy = 1'b0;
    chk("to_first_out", out_to, 8'h5a);
    core_state = UPD;
    step();
    core_state = NOP;

    issue(1'b1, 1'b0, 8'h45, 8'h00);
    repeat (3) step();
    chk("to_still_wait", st_to, 2'b10);
    chk("to_valid_held", rv_to, 1'b1);
    step();
    chk("to_done", st_to, 2'b11);
    chk("to_error", err_to, 1'b1);
    chk("to_out_kept", out_to, 8'h5a);
    chk("to_valid_drop", rv_to, 1'b0);
    core_state = UPD;
    step();
    core_state = NOP;

    // Ready on the limit cycle: normal completion wins
    issue(1'b1, 1'b0, 8'h46, 8'h00);
    chk("to_err_clear", err_to, 1'b0);
    repeat (3) step();
    rrdy = 1'b1;
    rdata = 8'hc3;
    step();
    rrdy = 1'b0;
    chk("edge_done", st_to, 2'b11);
    chk("edge_err", err_to, 1'b0);
    chk("edge_out", out_to, 8'hc3);
    core_state = UPD;
    step();
    core_state = NOP;
    en_to = 1'b0;

    step();
    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
